// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int DEF_WORD_BITWIDTH    = 32;
  localparam int DEF_REG_NUM_BITWIDTH = 5;
  localparam int DEF_CNT_BITWIDTH     = $clog2(DEF_WORD_BITWIDTH + 1);

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for a given operand width (must hold the value WORD_BITWIDTH).
  function automatic int cnt_bits(input int word_bits);
    return $clog2(word_bits + 1);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration shared by multiply (shift-add) and divide (restoring).
// The accumulator is 2*W bits for both: multiply keeps {partial product, multiplier},
// divide keeps {partial remainder, dividend/quotient}. For divide the quotient bit
// is returned separately and the low bit of acc_next is left 0.
module muldiv_step #(
  parameter int W = 32
) (
  input  logic           is_div,
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   operand,
  output logic [2*W-1:0] acc_next,
  output logic           q_bit
);

  logic [W:0]   sum;
  logic [W:0]   trial;
  logic [W-1:0] diff;

  // Compute both candidate updates, then pick by mode.
  always_comb begin
    sum      = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : '0);
    trial    = acc[2*W-1:W-1];
    // trial - operand always fits in W bits whenever it is selected
    diff     = trial[W-1:0] - operand;
    q_bit    = 1'b0;
    acc_next = {sum, acc[W-1:1]};
    if (is_div) begin
      q_bit    = (trial >= {1'b0, operand});
      acc_next = {(q_bit ? diff : trial[W-1:0]), acc[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide controller for the EX stage.
//
//   state | meaning
//   IDLE  | waiting for an M instruction in EX; latches operands on start
//   BUSY  | one shift-add / shift-subtract iteration per cycle
//   DONE  | result registered, result_valid high, pipeline released
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WORD_BITWIDTH    = DEF_WORD_BITWIDTH,
  parameter int REG_NUM_BITWIDTH = DEF_REG_NUM_BITWIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ex_isMulDiv,
  input  logic [2:0]                  ex_funct3,
  input  logic [WORD_BITWIDTH-1:0]    ex_Rs1Val,
  input  logic [WORD_BITWIDTH-1:0]    ex_Rs2Val,
  input  logic [REG_NUM_BITWIDTH-1:0] ex_Rd,
  input  logic                        flush,
  output logic                        stall,
  output logic [WORD_BITWIDTH-1:0]    result,
  output logic [REG_NUM_BITWIDTH-1:0] result_Rd,
  output logic                        result_valid
);

  localparam int W     = WORD_BITWIDTH;
  localparam int CNT_W = cnt_bits(W);

  state_t                      state;
  logic [2:0]                  op_q;
  logic [REG_NUM_BITWIDTH-1:0] rd_q;
  logic [CNT_W-1:0]            counter;
  logic [2*W-1:0]              acc;
  logic [W-1:0]                opnd;
  logic                        neg_res;
  logic                        neg_rem;

  logic           a_signed, b_signed, a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;
  logic           div_zero, div_ovf;
  logic [W-1:0]   short_res;
  logic [2*W-1:0] step_acc, acc_fin, prod;
  logic           q_bit;
  logic [W-1:0]   quo, rem, fin_res;

  // Operand sign handling and shortcut detection for a starting instruction.
  always_comb begin
    a_signed = (ex_funct3 == F3_MULH) || (ex_funct3 == F3_MULHSU) ||
               (ex_funct3 == F3_DIV)  || (ex_funct3 == F3_REM);
    b_signed = (ex_funct3 == F3_MULH) || (ex_funct3 == F3_DIV) ||
               (ex_funct3 == F3_REM);
    a_neg    = a_signed && ex_Rs1Val[W-1];
    b_neg    = b_signed && ex_Rs2Val[W-1];
    a_mag    = a_neg ? -ex_Rs1Val : ex_Rs1Val;
    b_mag    = b_neg ? -ex_Rs2Val : ex_Rs2Val;
    div_zero = ex_funct3[2] && (ex_Rs2Val == '0);
    div_ovf  = ((ex_funct3 == F3_DIV) || (ex_funct3 == F3_REM)) &&
               (ex_Rs1Val == {1'b1, {(W-1){1'b0}}}) && (ex_Rs2Val == '1);
    if (ex_funct3[1])
      short_res = div_zero ? ex_Rs1Val : '0;
    else
      short_res = div_zero ? '1 : {1'b1, {(W-1){1'b0}}};
  end

  muldiv_step #(.W(W)) u_step (
    .is_div   (op_q[2]),
    .acc      (acc),
    .operand  (opnd),
    .acc_next (step_acc),
    .q_bit    (q_bit)
  );

  // Final sign fix-up and word selection, applied to the last iteration's output.
  always_comb begin
    acc_fin = {step_acc[2*W-1:1], step_acc[0] | q_bit};
    prod    = neg_res ? -acc_fin : acc_fin;
    quo     = acc_fin[W-1:0];
    rem     = acc_fin[2*W-1:W];
    if (!op_q[2])
      fin_res = (op_q == F3_MUL) ? prod[W-1:0] : prod[2*W-1:W];
    else if (!op_q[1])
      fin_res = neg_res ? -quo : quo;
    else
      fin_res = neg_rem ? -rem : rem;
  end

  // Held low during reset so the hazard unit sees no stall from this block.
  assign stall = rst_n && ex_isMulDiv && (state != DONE) && !flush;

  // Sequencer FSM with registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_q         <= F3_MUL;
      rd_q         <= '0;
      counter      <= '0;
      acc          <= '0;
      opnd         <= '0;
      neg_res      <= 1'b0;
      neg_rem      <= 1'b0;
      result       <= '0;
      result_Rd    <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (flush) begin
        state   <= IDLE;
        counter <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (ex_isMulDiv) begin
              op_q    <= ex_funct3;
              rd_q    <= ex_Rd;
              opnd    <= b_mag;
              acc     <= {{W{1'b0}}, a_mag};
              neg_res <= a_neg ^ b_neg;
              neg_rem <= a_neg;
              if (div_zero || div_ovf) begin
                result       <= short_res;
                result_Rd    <= ex_Rd;
                result_valid <= 1'b1;
                state        <= DONE;
              end else begin
                counter <= CNT_W'(W);
                state   <= BUSY;
              end
            end
          end
          BUSY: begin
            acc     <= acc_fin;
            counter <= counter - 1'b1;
            if (counter == CNT_W'(1)) begin
              result       <= fin_res;
              result_Rd    <= rd_q;
              result_valid <= 1'b1;
              state        <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with an arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_isMulDiv;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_Rs1Val;
  logic [31:0] ex_Rs2Val;
  logic [4:0]  ex_Rd;
  logic        flush;
  logic        stall;
  logic [31:0] result;
  logic [4:0]  result_Rd;
  logic        result_valid;

  int n_vec = 0;
  int n_err = 0;

  muldiv_sequencer #(.WORD_BITWIDTH(32), .REG_NUM_BITWIDTH(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_isMulDiv  (ex_isMulDiv),
    .ex_funct3    (ex_funct3),
    .ex_Rs1Val    (ex_Rs1Val),
    .ex_Rs2Val    (ex_Rs2Val),
    .ex_Rd        (ex_Rd),
    .flush        (flush),
    .stall        (stall),
    .result       (result),
    .result_Rd    (result_Rd),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic following the RV32M rules.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'h0, b}); return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(posedge clk); #1;
    ex_isMulDiv = 1'b1;
    ex_funct3   = f3;
    ex_Rs1Val   = a;
    ex_Rs2Val   = b;
    ex_Rd       = rd;
  endtask

  // Runs one instruction to completion, checking stall/valid on every cycle.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] lit);
    logic [31:0] exp;
    int done;
    exp  = model(f3, a, b);
    done = latency(f3, a, b);
    chk("model_pin", exp, lit);
    start_op(f3, a, b, rd);
    for (int c = 0; c <= done; c++) begin
      @(negedge clk);
      chk("stall", {31'h0, stall}, {31'h0, (c < done)});
      chk("valid", {31'h0, result_valid}, {31'h0, (c == done)});
      if (c == done) begin
        chk("result", result, exp);
        chk("result_Rd", {27'h0, result_Rd}, {27'h0, rd});
      end
      @(posedge clk); #1;
    end
    ex_isMulDiv = 1'b0;
    @(negedge clk);
    chk("post_valid", {31'h0, result_valid}, 32'h0);
    chk("post_hold", result, exp);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lit;
  } vec_t;

  vec_t vecs[15] = '{
    '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
    '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF},
    '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
    '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
    '{3'd5, 32'd100,        32'd7,         32'd14},
    '{3'd7, 32'd100,        32'd7,         32'd2},
    '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF},
    '{3'd6, 32'd5,          32'd0,         32'd5},
    '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
    '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0},
    '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
    '{3'd1, 32'hFFFF_FFFD,  32'd5,         32'hFFFF_FFFF},
    '{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD},
    '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1}
  };

  initial begin
    rst_n       = 1'b0;
    ex_isMulDiv = 1'b0;
    ex_funct3   = 3'd0;
    ex_Rs1Val   = '0;
    ex_Rs2Val   = '0;
    ex_Rd       = '0;
    flush       = 1'b0;
    #2;
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_valid", {31'h0, result_valid}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_rd", {27'h0, result_Rd}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++)
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].lit);

    // Flush a DIV in its tenth cycle; it must vanish without a result.
    start_op(3'd4, 32'd1000, 32'd3, 5'd20);
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) flush = 1'b1;
      @(negedge clk);
      chk("fl_stall", {31'h0, stall}, {31'h0, (c < 10)});
      chk("fl_valid", {31'h0, result_valid}, 32'h0);
      @(posedge clk); #1;
    end
    flush       = 1'b0;
    ex_isMulDiv = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("fl_quiet_valid", {31'h0, result_valid}, 32'h0);
      chk("fl_quiet_stall", {31'h0, stall}, 32'h0);
    end
    run_op(3'd0, 32'd3, 32'd4, 5'd21, 32'd12);

    // Reset in the middle of a MUL: everything drops at once.
    start_op(3'd0, 32'd9, 32'd9, 5'd22);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_stall", {31'h0, stall}, 32'h0);
    chk("mrst_valid", {31'h0, result_valid}, 32'h0);
    chk("mrst_result", result, 32'h0);
    chk("mrst_rd", {27'h0, result_Rd}, 32'h0);
    ex_isMulDiv = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("mrst_idle_stall", {31'h0, stall}, 32'h0);
      chk("mrst_idle_valid", {31'h0, result_valid}, 32'h0);
    end
    run_op(3'd5, 32'd100, 32'd7, 5'd23, 32'd14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
